// File: rtl/accel_mmio_ctrl.sv
// accel_mmio_ctrl: MMIO control/status front end for the lane-detection
// accelerator: soft reset, busy/done/irq, frame and cycle counters, read mux.
// Ports: clk, rst_n (async, active-low); wr_en/wr_addr/wr_data/wr_strobe
// host write; rd_en/rd_addr -> rd_data/rd_valid (1-cycle registered read);
// out_rd_en/out_rd_addr/out_rd_data output-BRAM window; frame_start,
// frame_done from datapath; internal_rst_n, busy, irq to datapath/host.
// Build option: ACCEL_PERF_COUNTER_EN enables the CYCLE_COUNT counter.
module accel_mmio_ctrl #(
    parameter int AXI_ADDR_WIDTH    = 20,
    parameter int REG_BASE          = 395264,
    parameter int OUT_BASE          = 393216,
    parameter int OUT_BYTES         = 2048,
    parameter int SOFT_RESET_CYCLES = 16,
    localparam int OUT_AW           = $clog2(OUT_BYTES / 4)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    input  logic                      rd_en,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]               rd_data,
    output logic                      rd_valid,
    output logic                      out_rd_en,
    output logic [OUT_AW-1:0]         out_rd_addr,
    input  logic [31:0]               out_rd_data,
    input  logic                      frame_start,
    input  logic                      frame_done,
    output logic                      internal_rst_n,
    output logic                      busy,
    output logic                      irq
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] STATUS_A = AW'(REG_BASE);
    localparam logic [AW-1:0] CTRL_A   = AW'(REG_BASE + 4);
    localparam logic [AW-1:0] FCNT_A   = AW'(REG_BASE + 8);
    localparam logic [AW-1:0] CCNT_A   = AW'(REG_BASE + 12);
    localparam logic [AW-1:0] OUT_A    = AW'(OUT_BASE);
    localparam logic [AW-1:0] OUT_SZ   = AW'(OUT_BYTES);
    localparam logic [7:0]    SRST_LD  = 8'(SOFT_RESET_CYCLES);

    logic [7:0]    srst_cnt;
    logic          srst_active;
    logic          ctrl_wr;
    logic          srst_req;
    logic          done_clr;
    logic          irq_en;
    logic          frame_done_d;
    logic          fd_rise;
    logic          busy_r;
    logic          done;
    logic          start_acc;
    logic          end_acc;
    logic [31:0]   frame_cnt;
    logic [31:0]   cycle_cnt;
    logic [AW-1:0] rd_off;
    logic          in_win;
    logic [31:0]   reg_rdata;
    logic [31:0]   rd_reg_q;
    logic          rd_bram;
    logic          unused_bits;

    assign srst_active = (srst_cnt != 8'd0);
    assign ctrl_wr     = wr_en && (wr_addr == CTRL_A) && wr_strobe[0];
    assign srst_req    = ctrl_wr && wr_data[0];
    assign done_clr    = ctrl_wr && wr_data[2];
    assign fd_rise     = frame_done && !frame_done_d;
    assign start_acc   = frame_start && !busy_r && !srst_active;
    assign end_acc     = fd_rise && busy_r && !srst_active;

    assign internal_rst_n = rst_n && !srst_active;
    assign busy           = busy_r && !frame_done;
    assign irq            = irq_en && done;

    // Soft reset counter: only a write seen while idle starts a new pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srst_cnt <= 8'd0;
        end else if (srst_active) begin
            srst_cnt <= srst_cnt - 8'd1;
        end else if (srst_req) begin
            srst_cnt <= SRST_LD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en       <= 1'b0;
            frame_done_d <= 1'b0;
            frame_cnt    <= 32'd0;
        end else begin
            frame_done_d <= frame_done;
            if (ctrl_wr) begin
                irq_en <= wr_data[1];
            end
            if (end_acc) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    // Done-set outranks done-clear; frame_start clears done regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done   <= 1'b0;
        end else if (srst_active) begin
            busy_r <= 1'b0;
            done   <= 1'b0;
        end else if (start_acc) begin
            busy_r <= 1'b1;
            done   <= 1'b0;
        end else if (end_acc) begin
            busy_r <= 1'b0;
            done   <= 1'b1;
        end else if (done_clr) begin
            done <= 1'b0;
        end
    end

`ifdef ACCEL_PERF_COUNTER_EN
    // Saturating; cleared at frame start so it holds the last frame's length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= 32'd0;
        end else if (srst_active || start_acc) begin
            cycle_cnt <= 32'd0;
        end else if (busy_r && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = 32'd0;
`endif

    assign rd_off      = rd_addr - OUT_A;
    assign in_win      = (rd_addr >= OUT_A) && (rd_off < OUT_SZ);
    assign out_rd_en   = rd_en && in_win;
    assign out_rd_addr = rd_off[OUT_AW+1:2];

    always_comb begin
        reg_rdata = 32'd0;
        case (rd_addr)
            STATUS_A: reg_rdata = {16'd0, frame_cnt[7:0], 5'd0, irq, busy, done};
            CTRL_A:   reg_rdata = {30'd0, irq_en, 1'b0};
            FCNT_A:   reg_rdata = frame_cnt;
            CCNT_A:   reg_rdata = cycle_cnt;
            default:  reg_rdata = 32'd0;
        endcase
    end

    // Register reads are captured at request time; BRAM data arrives a
    // cycle later, so only the source select is registered for that path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_bram  <= 1'b0;
            rd_reg_q <= 32'd0;
        end else begin
            rd_valid <= rd_en;
            rd_bram  <= out_rd_en;
            rd_reg_q <= rd_en ? reg_rdata : 32'd0;
        end
    end

    assign rd_data = rd_bram ? out_rd_data : rd_reg_q;

    assign unused_bits = ^{wr_data[31:3], wr_strobe[3:1],
                           rd_off[1:0], rd_off[AW-1:OUT_AW+2]};

endmodule

// File: tb/tb_accel_mmio_ctrl.sv
// tb_accel_mmio_ctrl: directed self-checking bench for accel_mmio_ctrl.
// Vectors and expected values are hand-computed for default parameters.
module tb_accel_mmio_ctrl;

    localparam logic [19:0] STATUS_A = 20'h60800;
    localparam logic [19:0] CTRL_A   = 20'h60804;
    localparam logic [19:0] FCNT_A   = 20'h60808;
    localparam logic [19:0] CCNT_A   = 20'h6080C;
    localparam logic [19:0] OUT_A    = 20'h60000;

`ifdef ACCEL_PERF_COUNTER_EN
    localparam logic [31:0] EXP_CC1 = 32'd101;
    localparam logic [31:0] EXP_CC2 = 32'd9;
`else
    localparam logic [31:0] EXP_CC1 = 32'd0;
    localparam logic [31:0] EXP_CC2 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [19:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        out_rd_en;
    logic [8:0]  out_rd_addr;
    logic [31:0] out_rd_data;
    logic        frame_start;
    logic        frame_done;
    logic        internal_rst_n;
    logic        busy;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    accel_mmio_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_strobe      (wr_strobe),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .out_rd_en      (out_rd_en),
        .out_rd_addr    (out_rd_addr),
        .out_rd_data    (out_rd_data),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .internal_rst_n (internal_rst_n),
        .busy           (busy),
        .irq            (irq)
    );

    // BRAM stand-in: word n holds 0xA500_0000 | n, one-cycle latency.
    always_ff @(posedge clk) begin
        if (out_rd_en) begin
            out_rd_data <= 32'hA500_0000 | 32'(out_rd_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        wr_en     = 1'b1;
        wr_addr   = CTRL_A;
        wr_data   = d;
        wr_strobe = 4'b0001;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [19:0] a,
                      input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        int lows;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_strobe   = '0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        repeat (3) tick();
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_int_rst_n", 32'(internal_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_out_rd_en", 32'(out_rd_en), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("int_rst_n_up", 32'(internal_rst_n), 32'd1);

        rd("rst_status", STATUS_A, 32'd0);
        rd("rst_ctrl", CTRL_A, 32'd0);
        rd("rst_fcnt", FCNT_A, 32'd0);
        rd("rst_ccnt", CCNT_A, 32'd0);

        // Output window: top word then base word back to back.
        rd_en   = 1'b1;
        rd_addr = OUT_A + 20'h7FC;
        #1;
        chk("win_top_en", 32'(out_rd_en), 32'd1);
        chk("win_top_addr", 32'(out_rd_addr), 32'd511);
        tick();
        rd_addr = OUT_A;
        chk("win_top_valid", 32'(rd_valid), 32'd1);
        chk("win_top_data", rd_data, 32'hA500_01FF);
        tick();
        rd_en = 1'b0;
        chk("win_base_valid", 32'(rd_valid), 32'd1);
        chk("win_base_data", rd_data, 32'hA500_0000);
        tick();
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);

        // Just past the window (aliases STATUS, which is still 0 here).
        rd_en   = 1'b1;
        rd_addr = OUT_A + 20'd2048;
        #1;
        chk("win_past_en", 32'(out_rd_en), 32'd0);
        rd_en = 1'b0;
        rd("win_past", OUT_A + 20'd2048, 32'd0);
        rd("below_win", OUT_A - 20'd4, 32'd0);

        // Frame: irq enabled, start, 100 idle cycles, frame_done level.
        wr_ctrl(32'h2);
        rd("ctrl_irq_en", CTRL_A, 32'h2);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (100) tick();
        frame_done = 1'b1;
        #1;
        chk("busy_falls", 32'(busy), 32'd0);
        chk("irq_before_edge", 32'(irq), 32'd0);
        tick();
        chk("irq_after_done", 32'(irq), 32'd1);
        rd("status_done", STATUS_A, 32'h0000_0105);
        rd("fcnt_1", FCNT_A, 32'd1);
        rd("ccnt_1", CCNT_A, EXP_CC1);
        wr_ctrl(32'h6);
        chk("irq_cleared", 32'(irq), 32'd0);
        rd("status_cleared", STATUS_A, 32'h0000_0100);
        frame_done = 1'b0;
        tick();

        // Second frame: restart while busy, then done-clear with the edge.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (4) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        frame_done = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = CTRL_A;
        wr_data    = 32'h6;
        wr_strobe  = 4'b0001;
        tick();
        wr_en = 1'b0;
        chk("done_wins_clear", 32'(irq), 32'd1);
        rd("status_f2", STATUS_A, 32'h0000_0205);
        rd("ccnt_2", CCNT_A, EXP_CC2);
        frame_done = 1'b0;
        tick();

        // frame_start together with done-clear: done ends low.
        frame_start = 1'b1;
        wr_en       = 1'b1;
        wr_data     = 32'h6;
        tick();
        frame_start = 1'b0;
        wr_en       = 1'b0;
        rd("status_start_clr", STATUS_A, 32'h0000_0202);

        // Soft reset with a retrigger five cycles in.
        wr_ctrl(32'h3);
        lows = 0;
        for (int i = 1; i <= 20; i++) begin
            if (!internal_rst_n) lows++;
            if (i == 5) begin
                wr_en   = 1'b1;
                wr_addr = CTRL_A;
                wr_data = 32'h3;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        chk("srst_len", 32'(lows), 32'd16);
        chk("srst_released", 32'(internal_rst_n), 32'd1);
        rd("status_srst", STATUS_A, 32'h0000_0200);
        rd("fcnt_srst", FCNT_A, 32'd2);
        rd("ctrl_srst", CTRL_A, 32'h2);
        rd("ccnt_srst", CCNT_A, 32'd0);
        rd("unaligned", STATUS_A + 20'd2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
